// File: rtl/ef_smsdac_tree_enc8.sv
// Tree-structured first-order mismatch-shaping encoder: 0..8 code -> 8 unit-element enables.
// Optional EF_SMSDAC_SHAPE_BYPASS_EN adds shape_en, which selects a plain thermometer output.
module ef_smsdac_tree_enc8 (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       en,
`ifdef EF_SMSDAC_SHAPE_BYPASS_EN
  input  logic       shape_en,
`endif
  input  logic [3:0] din,
  input  logic [6:0] r,
  output logic [7:0] dout,
  output logic       sat
);

  typedef struct packed {
    logic [1:0] a_nxt;
    logic [3:0] up;
    logic [3:0] lo;
  } blk_t;

  localparam logic [1:0] A_ZERO = 2'b00;
  localparam logic [1:0] A_POS  = 2'b01;
  localparam logic [1:0] A_NEG  = 2'b11;

  // One switching block. The odd unit goes up when s=+1, down when s=-1.
  // The unreachable code 2'b10 falls through to the a=0 branch.
  function automatic blk_t sw_block(input logic [3:0] c, input logic [1:0] a, input logic rb);
    blk_t o;
    logic up_gets_odd;
    up_gets_odd = 1'b0;
    o.a_nxt = a;
    o.up    = c >> 1;
    o.lo    = c >> 1;
    if (c[0]) begin
      if (a == A_POS) begin
        up_gets_odd = 1'b0;
        o.a_nxt     = A_ZERO;
      end else if (a == A_NEG) begin
        up_gets_odd = 1'b1;
        o.a_nxt     = A_ZERO;
      end else begin
        up_gets_odd = rb;
        o.a_nxt     = rb ? A_POS : A_NEG;
      end
      if (up_gets_odd) o.up = o.up + 4'd1;
      else             o.lo = o.lo + 4'd1;
    end
    return o;
  endfunction

  logic [3:0] c1;
  logic [1:0] a_reg  [7];
  logic [1:0] a_next [7];
  logic [3:0] c_l2   [2];
  logic [3:0] c_l3   [4];
  logic [7:0] shaped;
  logic [7:0] dout_next;
  logic       state_upd;
  logic [7:0] dout_reg;
  logic       sat_reg;

  assign c1 = (din > 4'd8) ? 4'd8 : din;

  // Block numbering follows r: 0 = layer 1, 1..2 = layer 2, 3..6 = layer 3.
  blk_t l1;
  assign l1        = sw_block(c1, a_reg[0], r[0]);
  assign a_next[0] = l1.a_nxt;
  assign c_l2[0]   = l1.lo;
  assign c_l2[1]   = l1.up;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_l2
      blk_t res;
      assign res              = sw_block(c_l2[gi], a_reg[1+gi], r[1+gi]);
      assign a_next[1+gi]     = res.a_nxt;
      assign c_l3[2*gi]       = res.lo;
      assign c_l3[2*gi+1]     = res.up;
    end

    // Leaf counts are 0 or 1, so OR-reducing yields the element enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_l3
      blk_t res;
      assign res              = sw_block(c_l3[gi], a_reg[3+gi], r[3+gi]);
      assign a_next[3+gi]     = res.a_nxt;
      assign shaped[2*gi]     = |res.lo;
      assign shaped[2*gi+1]   = |res.up;
    end
  endgenerate

`ifdef EF_SMSDAC_SHAPE_BYPASS_EN
  logic [7:0] therm;
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_therm
      assign therm[gi] = (c1 > 4'(gi));
    end
  endgenerate
  assign dout_next = shape_en ? shaped : therm;
  assign state_upd = shape_en;
`else
  assign dout_next = shaped;
  assign state_upd = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dout_reg <= 8'h00;
      sat_reg  <= 1'b0;
      for (int k = 0; k < 7; k++) a_reg[k] <= A_ZERO;
    end else if (en) begin
      dout_reg <= dout_next;
      sat_reg  <= (din > 4'd8);
      if (state_upd) begin
        for (int k = 0; k < 7; k++) a_reg[k] <= a_next[k];
      end
    end
  end

  assign dout = dout_reg;
  assign sat  = sat_reg;

endmodule
